fifo_serial_tx: RTL
===================

Name: fifo_serial_tx

Overview:
- Read-side companion to the bus FIFO: drains 32-bit words from the FIFO's dequeue port and transmits each word LSB-first as a framed serial stream on the system bus.
- Sits between the FIFO's read port (deq/data_out/valid/empty) and the serial bus link.
- The link has a per-bit ready handshake so a slow receiver can stall the stream.

Parameters:
- WIDTH, 32, word width; must equal the FIFO WIDTH.
- CNT_WIDTH, 16, width of the sent-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag (registered in the FIFO).
- fifo_data  input  WIDTH  FIFO data_out.
- fifo_valid  input  1  FIFO valid; high the cycle after an accepted deq.
- fifo_deq  output  1  dequeue request, 1-cycle pulse.
- tx_bit  output  1  serial data bit.
- tx_valid  output  1  tx_bit is valid.
- tx_last  output  1  marks the final bit of the frame.
- tx_ready  input  1  receiver accepts the current bit this cycle.
- busy  output  1  high in any state other than IDLE.
- words_sent  output  CNT_WIDTH  count of completed frames.

Behaviour:
- Reset (rst=1, async): state IDLE; fifo_deq=0, tx_bit=0, tx_valid=0, tx_last=0, busy=0, words_sent=0; shift register and bit index cleared.
- FSM states: IDLE, REQ, WAIT, SHIFT, PARITY (PARITY exists only with the optional feature).
- IDLE: if fifo_empty=0, go to REQ.
- REQ: fifo_deq=1 for exactly one cycle, then go to WAIT. Only one outstanding deq at a time; fifo_deq is never asserted in any other state.
- WAIT: on fifo_valid=1, latch fifo_data into the shift register, set bit index to 0, go to SHIFT. With no valid, stay in WAIT indefinitely; fifo_deq stays low.
- SHIFT:
  - tx_valid=1; tx_bit = shreg[0].
  - Bit transfers on the cycle where tx_valid & tx_ready.
  - On transfer: shift right by one, increment bit index.
  - If tx_ready=0: tx_bit and tx_valid hold stable (no retraction).
  - tx_last=1 while the bit index equals WIDTH-1, parity disabled.
  - Transfer of bit WIDTH-1: go to PARITY if enabled; otherwise IDLE and increment words_sent.
- PARITY: see Optional Feature.
- Latency and throughput:
  - Minimum latency, fifo_empty deasserted to first tx_valid: 3 cycles (IDLE→REQ→WAIT→SHIFT).
  - Back-to-back words have a 3-cycle gap with tx_valid=0.
- words_sent: CNT_WIDTH-bit unsigned; wraps from 2^CNT_WIDTH-1 to 0.
- Boundary conditions:
  - fifo_empty rising while in WAIT is ignored; the word already dequeued completes.
  - fifo_valid seen outside WAIT is ignored.
  - Reset mid-frame: frame aborts immediately and all outputs go to reset values. The in-flight word is lost and is not recounted.
  - tx_ready held high continuously: one bit per cycle.

Optional Feature:
- Macro: FIFO_SERIAL_TX_PARITY_EN.
- Defined:
  - After the data bits, the PARITY state sends one extra bit with tx_valid=1 and tx_last=1.
  - The bit is even parity: XOR of the latched word.
  - It holds until tx_ready; on transfer, go to IDLE and increment words_sent.
  - Frame length is WIDTH+1; tx_last is not asserted on data bit WIDTH-1.
- Undefined: PARITY state and parity register are absent; frame length is WIDTH.

Decomposition:
- Shared package: FSM state enum (tx_state_t) and a default word-width constant shared with the FIFO instance.
- Natural sub-module: piso_shifter (load, shift-enable, serial out, bit index, last flag).
- FSM and counter stay in the top module.

Test Plan:
- Single word: FIFO holds 0x0000_0001, tx_ready=1.
  - Exactly one fifo_deq pulse.
  - tx_valid high 32 consecutive cycles starting 3 cycles after fifo_empty falls.
  - tx_bit = 1 then 31 zeros; tx_last only on the 32nd bit; words_sent=1.
- Stall: word 0xA5A5_A5A5, tx_ready low on bits 3-5 for 4 cycles each.
  - tx_bit and tx_valid are stable during each stall.
  - Received bits reassemble to 0xA5A5_A5A5.
- Back-to-back: FIFO holds 3 words, tx_ready=1.
  - 3 deq pulses, each issued only after the previous frame's last bit.
  - 3-cycle gaps between frames; words_sent=3.
- Reset mid-frame: assert rst at bit 10 of 0xFFFF_FFFF.
  - Outputs are 0 in the same cycle (async).
  - After release, state is IDLE and words_sent=0.
- Counter wrap: CNT_WIDTH=4, send 17 words → words_sent=1.
- Parity (macro defined): word 0x0000_0007 → 33rd bit = 1 with tx_last; word 0x0000_0003 → 33rd bit = 0.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// ============================================================================
// Module      : fifo_serial_tx_pkg
// Description : Shared definitions for the FIFO serial transmitter: FSM state
//               encoding and the default word width that must match the bus
//               FIFO feeding the transmitter.
// Optional    : FIFO_SERIAL_TX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_serial_tx_pkg;

  // Default word width, shared with the bus FIFO instance.
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SHIFT  = 3'd3
`ifdef FIFO_SERIAL_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_serial_tx_piso_shifter.sv
// ============================================================================
// Module      : fifo_serial_tx_piso_shifter
// Description : Parallel-in / serial-out shifter, LSB first. Loads a word,
//               shifts right by one on each enabled cycle and tracks the
//               index of the bit currently presented on bit_o.
// Ports       : clk, rst      - clock, async active-high reset
//               load_i        - capture data_i, index back to 0
//               data_i        - word to serialise
//               shift_i       - advance to the next bit
//               bit_o         - current serial bit (register bit 0)
//               idx_o         - index of the bit on bit_o
//               last_o        - bit_o is the final data bit of the word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_serial_tx_piso_shifter #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = data_i;
      idx_d   = '0;
    end else if (shift_i) begin
      // Zero fill keeps bit_o low once the whole word has gone out.
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign bit_o  = shreg_q[0];
  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/fifo_serial_tx.sv
// ============================================================================
// Module      : fifo_serial_tx
// Description : Drains words from the bus FIFO read port and transmits each
//               one LSB first as a framed serial stream with a per-bit
//               ready handshake. One dequeue is outstanding at a time.
// Optional    : define FIFO_SERIAL_TX_PARITY_EN to append an even-parity bit
//               (frame length WIDTH+1, tx_last moves to the parity bit).
// Ports       : clk, rst      - clock, async active-high reset
//               fifo_empty    - FIFO empty flag
//               fifo_data     - FIFO data_out
//               fifo_valid    - FIFO data valid, cycle after an accepted deq
//               fifo_deq      - one-cycle dequeue request
//               tx_bit        - serial data bit
//               tx_valid      - tx_bit is valid
//               tx_last       - final bit of the frame
//               tx_ready      - receiver accepts the current bit
//               busy          - transmitter not idle
//               words_sent    - completed frame count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  input  logic                 fifo_valid,
  output logic                 fifo_deq,
  output logic                 tx_bit,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent
);

  localparam int IDX_W = $clog2(WIDTH);

  tx_state_t            state_q;
  logic                 fifo_deq_q;
  logic                 tx_valid_q;
  logic                 tx_last_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] words_sent_q;

  logic                 sh_load;
  logic                 sh_shift;
  logic                 sh_bit;
  logic [IDX_W-1:0]     sh_idx;
  logic                 sh_last;

  // fifo_valid outside WAIT is ignored: only WAIT can load the shifter.
  assign sh_load  = (state_q == ST_WAIT) && fifo_valid;
  assign sh_shift = (state_q == ST_SHIFT) && tx_ready;

  fifo_serial_tx_piso_shifter #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .data_i  (fifo_data),
    .shift_i (sh_shift),
    .bit_o   (sh_bit),
    .idx_o   (sh_idx),
    .last_o  (sh_last)
  );

`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic par_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fifo_deq_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ST_REQ;
            fifo_deq_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ST_REQ: begin
          state_q    <= ST_WAIT;
          fifo_deq_q <= 1'b0;
        end

        ST_WAIT: begin
          if (fifo_valid) begin
            state_q    <= ST_SHIFT;
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            par_q      <= ^fifo_data;
`endif
          end
        end

        ST_SHIFT: begin
          if (tx_ready) begin
            if (sh_last) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
              state_q      <= ST_PARITY;
              tx_last_q    <= 1'b1;
`else
              state_q      <= ST_IDLE;
              tx_valid_q   <= 1'b0;
              tx_last_q    <= 1'b0;
              busy_q       <= 1'b0;
              words_sent_q <= words_sent_q + CNT_WIDTH'(1);
`endif
            end else begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
              tx_last_q <= 1'b0;
`else
              // Raise tx_last together with the final data bit.
              tx_last_q <= (sh_idx == IDX_W'(WIDTH - 2));
`endif
            end
          end
        end

`ifdef FIFO_SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (tx_ready) begin
            state_q      <= ST_IDLE;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            words_sent_q <= words_sent_q + CNT_WIDTH'(1);
          end
        end
`endif

        default: begin
          state_q    <= ST_IDLE;
          fifo_deq_q <= 1'b0;
          tx_valid_q <= 1'b0;
          tx_last_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_SERIAL_TX_PARITY_EN
  // The shifter is all zeros during PARITY, so the parity bit is muxed in.
  assign tx_bit = (state_q == ST_PARITY) ? par_q : sh_bit;
`else
  assign tx_bit = sh_bit;
`endif

  assign fifo_deq   = fifo_deq_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule

`default_nettype wire
